// File: rtl/beamformer_sequencer.sv
// beamformer_sequencer: frame sequencer driving brambeamformer load/filter/flush/beamform/sum flow
module beamformer_sequencer #(
  parameter int SIG_AW    = 11,
  parameter int N_SIG     = 2048,
  parameter int SUM_AW    = 10,
  parameter int N_SUM     = 540,
  parameter int LOAD_CYC  = 2,
  parameter int FLUSH_CYC = 6,
  parameter int IDX_W     = 16,
  parameter int IDX_INIT  = -2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic              valid_out,
  input  logic              usedataflag,
  output logic              bf_rst,
  output logic              start,
  output logic              signalinen,
  output logic [SIG_AW-1:0] signal_address,
  output logic [SIG_AW-1:0] readin_address,
  output logic [SUM_AW-1:0] sumout_address,
  output logic              filter_bram_output_write_en,
  output logic              output_read_en,
  output logic              startbeamformer,
  output logic              sumouten,
  output logic [IDX_W-1:0]  sample_index,
  output logic [1:0]        slice_state
);
  typedef enum logic [2:0] {IDLE, LOADIN, FILTER, FLUSH, BEAMFORM, SUM, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic prev_ud, fall, cnt_end, sig_end, sum_end, flush_exit, stay_bf;
  logic [1:0] slice_n;
  assign fall = (state == BEAMFORM) & prev_ud & ~usedataflag;
  assign cnt_end = cnt == 4'(state == LOADIN ? LOAD_CYC - 1 : FLUSH_CYC - 1);
  assign sig_end = signal_address == SIG_AW'(N_SIG - 1);
  assign sum_end = sumout_address == SUM_AW'(N_SUM - 1);
  assign flush_exit = (state == FLUSH) & cnt_end;
  assign stay_bf = (state == BEAMFORM) & (state_n == BEAMFORM);
  assign slice_n = stay_bf ? slice_state + 2'd1 : 2'd0;
  assign filter_bram_output_write_en = valid_out & ((state == FILTER) | (state == FLUSH));
  // next-state selection for the frame flow
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = go ? LOADIN : IDLE;
      LOADIN:   state_n = cnt_end ? FILTER : LOADIN;
      FILTER:   state_n = sig_end ? FLUSH : FILTER;
      FLUSH:    state_n = cnt_end ? BEAMFORM : FLUSH;
      BEAMFORM: state_n = (fall & sum_end) ? SUM : BEAMFORM;
      SUM:      state_n = sum_end ? DONE : SUM;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // state register, counters and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      prev_ud         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bf_rst          <= 1'b0;
      start           <= 1'b0;
      signalinen      <= 1'b0;
      output_read_en  <= 1'b0;
      startbeamformer <= 1'b0;
      sumouten        <= 1'b0;
      signal_address  <= '0;
      readin_address  <= '0;
      sumout_address  <= '0;
      sample_index    <= IDX_W'(IDX_INIT);
      slice_state     <= 2'd0;
    end else begin
      state           <= state_n;
      cnt             <= (state_n == state && (state == LOADIN || state == FLUSH)) ? cnt + 4'd1 : 4'd0;
      prev_ud         <= (state == BEAMFORM) & usedataflag;
      busy            <= state_n != IDLE;
      done            <= state_n == DONE;
      bf_rst          <= state_n inside {LOADIN, FILTER, FLUSH};
      start           <= state_n inside {FILTER, FLUSH};
      signalinen      <= state_n inside {LOADIN, FILTER, FLUSH};
      output_read_en  <= state_n == BEAMFORM;
      startbeamformer <= state_n == BEAMFORM;
      sumouten        <= state_n == SUM;
      signal_address  <= state == FILTER ? signal_address + 1'b1 :
                         state == LOADIN ? '0 : signal_address;
      readin_address  <= (flush_exit || (state == IDLE && go)) ? '0 :
                         ((state == FILTER || state == FLUSH) && valid_out) ? readin_address + 1'b1 :
                         (stay_bf && slice_n == 2'd3) ? readin_address + 1'b1 : readin_address;
      sumout_address  <= state == FLUSH ? '0 :
                         (fall || state == SUM) ? (sum_end ? '0 : sumout_address + 1'b1) : sumout_address;
      sample_index    <= flush_exit ? IDX_W'(IDX_INIT) :
                         slice_n != 2'd0 ? sample_index + 1'b1 : sample_index;
      slice_state     <= slice_n;
    end
  end
endmodule
